// File: rtl/seq_player_rl.sv
// Table-driven digit-sequence player: a writable DEPTH-entry table is walked by a pointer that
// steps forward/backward in wrap or saturate mode, with the selected entry registered on oNum.
module seq_player_rl #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 12,
  parameter int unsigned PTR_W  = 4
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iEn,
  input  logic              iDir,
  input  logic              iMode,
  input  logic              iLoad,
  input  logic [PTR_W-1:0]  iLoadPtr,
  input  logic              iWe,
  input  logic [PTR_W-1:0]  iWaddr,
  input  logic [DATA_W-1:0] iWdata,
  output logic [DATA_W-1:0] oNum,
  output logic [PTR_W-1:0]  oPtr,
  output logic              oValid,
  output logic              oWrap,
  output logic              oEnd
);

  localparam logic [PTR_W:0] LastIdx = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0] OneExt  = (PTR_W+1)'(1);

  logic [DATA_W-1:0] table_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] num_q, num_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;
  logic              end_q, end_d;

  logic [PTR_W:0]    cur_ext, load_ext, next_ext;
  logic              we_ok;

  assign cur_ext  = {1'b0, ptr_q};
  assign load_ext = {1'b0, iLoadPtr};
  assign we_ok    = iWe && ({1'b0, iWaddr} <= LastIdx);

  always_comb begin
    next_ext = cur_ext;
    wrap_d   = 1'b0;
    if (iLoad) begin
      next_ext = (load_ext > LastIdx) ? LastIdx : load_ext;
    end else if (iEn) begin
      if (iDir) begin
        if (cur_ext == LastIdx) begin
          if (!iMode) begin
            next_ext = '0;
            wrap_d   = 1'b1;
          end
        end else begin
          next_ext = cur_ext + OneExt;
        end
      end else begin
        if (cur_ext == '0) begin
          if (!iMode) begin
            next_ext = LastIdx;
            wrap_d   = 1'b1;
          end
        end else begin
          next_ext = cur_ext - OneExt;
        end
      end
    end
    ptr_d   = next_ext[PTR_W-1:0];
    end_d   = iMode && (iDir ? (next_ext == LastIdx) : (next_ext == '0));
    valid_d = valid_q || iLoad || iEn;
    // Write-through keeps oNum coherent with a same-cycle write to the new pointer.
    if (we_ok && (iWaddr == ptr_d)) begin
      num_d = iWdata;
    end else begin
      num_d = table_q[ptr_d];
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        table_q[i] <= '0;
      end
    end else if (we_ok) begin
      table_q[iWaddr] <= iWdata;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ptr_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      end_q   <= end_d;
    end
  end

  assign oNum   = num_q;
  assign oPtr   = ptr_q;
  assign oValid = valid_q;
  assign oWrap  = wrap_q;
  assign oEnd   = end_q;

endmodule
